// File: rtl/apb_req_arbiter_if.sv
// Requester, APB-master command and APB bus-monitor signals shared by the arbiter.
// slave = arbiter view, master = requester/bus side view.
interface apb_req_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_write;
   logic [NUM_REQ-1:0][31:0] req_addr;
   logic [NUM_REQ-1:0][31:0] req_wdata;
   logic [NUM_REQ-1:0][3:0]  req_strb;
   logic [NUM_REQ-1:0][2:0]  req_prot;
   logic [NUM_REQ-1:0]       req_grant;
   logic [NUM_REQ-1:0]       req_done;
   logic [31:0]              req_rdata;
   logic                     req_slverr;
   logic                     req_timeout;
   logic                     transfer;
   logic                     SWRITE;
   logic [31:0]              SADDR;
   logic [31:0]              SWDATA;
   logic [3:0]               SSTRB;
   logic [2:0]               SPROT;
   logic                     PSEL;
   logic                     PENABLE;
   logic                     PREADY;
   logic                     PSLVERR;
   logic [31:0]              PRDATA;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
      input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
      output req_grant, req_done, req_rdata, req_slverr, req_timeout,
      output transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
      output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
      input  req_grant, req_done, req_rdata, req_slverr, req_timeout,
      input  transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT
   );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NUM_REQ requesters;
// owns the port for one full transfer and returns status with a single done pulse.
module apb_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   apb_req_arbiter_if.slave   bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t             state, state_nx;
   logic [IDX_W-1:0]   last, win, cand;
   logic [NUM_REQ-1:0] win_oh, grant;
   logic               found, any_req, bus_done, tmo;
   logic [CNT_W-1:0]   cnt;
   logic               swrite, slverr, timeout;
   logic [31:0]        saddr, swdata, rdata;
   logic [3:0]         sstrb;
   logic [2:0]         sprot;

   assign any_req  = |bus.req_valid;
   assign bus_done = bus.PSEL & bus.PENABLE & bus.PREADY;
   assign tmo      = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Search starts just past the previous winner so the last owner ranks lowest.
   always_comb begin
      found  = 1'b0;
      win    = last;
      cand   = last;
      win_oh = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      win_oh[win] = 1'b1;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_req) state_nx = ISSUE;
         ISSUE:   if (bus.PSEL) state_nx = WAIT;
         WAIT:    if (bus_done || tmo) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= IDLE;
         last    <= IDX_W'(NUM_REQ - 1);
         grant   <= '0;
         cnt     <= '0;
         swrite  <= 1'b0;
         saddr   <= '0;
         swdata  <= '0;
         sstrb   <= '0;
         sprot   <= '0;
         rdata   <= '0;
         slverr  <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: if (any_req) begin
               last   <= win;
               grant  <= win_oh;
               swrite <= bus.req_write[win];
               saddr  <= bus.req_addr[win];
               swdata <= bus.req_wdata[win];
               sstrb  <= bus.req_write[win] ? bus.req_strb[win] : 4'b0000;
               sprot  <= bus.req_prot[win];
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               // A real completion beats a coincident timeout.
               if (bus_done) begin
                  rdata   <= bus.PRDATA;
                  slverr  <= bus.PSLVERR;
                  timeout <= 1'b0;
               end else if (tmo) begin
                  rdata   <= '0;
                  slverr  <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            DONE:    grant <= '0;
            default: ;
         endcase
      end
   end

   assign bus.transfer    = (state == ISSUE);
   assign bus.req_done    = (state == DONE) ? grant : '0;
   assign bus.req_grant   = grant;
   assign bus.req_rdata   = rdata;
   assign bus.req_slverr  = slverr;
   assign bus.req_timeout = timeout;
   assign bus.SWRITE      = swrite;
   assign bus.SADDR       = saddr;
   assign bus.SWDATA      = swdata;
   assign bus.SSTRB       = sstrb;
   assign bus.SPROT       = sprot;

   a_grant_onehot: assert property (@(posedge PCLK) disable iff (!PRESETn) $onehot0(grant));
   a_xfer_issue:   assert property (@(posedge PCLK) disable iff (!PRESETn) bus.transfer |-> (state == ISSUE));
endmodule
